// File: rtl/exec_pkg.sv
// Shared encodings for the execute stage: ALU ops, mul/div ops, FSM states.
package exec_pkg;

  localparam int unsigned MD_CYCLES_NOM = 33;

  // Writeback control bit positions inside wbi/wbo
  localparam int unsigned WB_REGWRITE = 1;
  localparam int unsigned WB_MEMTOREG = 0;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11,
    ALU_MFHI = 4'd12,
    ALU_MFLO = 4'd13
  } aluop_e;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } mdop_e;

  typedef enum logic [1:0] {
    MDS_IDLE = 2'd0,
    MDS_RUN  = 2'd1,
    MDS_FIX  = 2'd2
  } md_state_e;

endpackage

// File: rtl/execute_muldiv.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, followed by a single sign fix-up cycle into HI/LO.
module muldiv
  import exec_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned MD_CYCLES = MD_CYCLES_NOM
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_busy
);

  localparam int unsigned CW = $clog2(MD_CYCLES);

  md_state_e          r_state;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_acc;   // product high half / partial remainder
  logic [WIDTH-1:0]   r_q;     // multiplier / dividend-then-quotient
  logic [WIDTH-1:0]   r_m;     // multiplicand / divisor magnitude
  logic               r_is_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_dz;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  mdop_e              w_op;
  logic               w_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;

  // Operand decode and one iteration of multiply / divide datapath
  always_comb begin
    w_op       = mdop_e'(i_op);
    w_signed   = (w_op == MD_MULT) || (w_op == MD_DIV);
    w_a_neg    = w_signed & i_a[WIDTH-1];
    w_b_neg    = w_signed & i_b[WIDTH-1];
    w_a_mag    = w_a_neg ? (~i_a + 1'b1) : i_a;
    w_b_mag    = w_b_neg ? (~i_b + 1'b1) : i_b;
    w_sum      = {1'b0, r_acc} + {1'b0, (r_q[0] ? r_m : '0)};
    w_diff     = {r_acc, r_q[WIDTH-1]} - {1'b0, r_m};
    w_prod     = {r_acc, r_q};
    w_prod_fix = r_neg_q ? (~w_prod + 1'b1) : w_prod;
  end

  // Mul/div sequencer: IDLE -> RUN (WIDTH iterations) -> FIX -> IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= MDS_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_q      <= '0;
      r_m      <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      case (r_state)
        MDS_IDLE: begin
          if (i_start) begin
            r_state  <= MDS_RUN;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_q      <= w_a_mag;
            r_m      <= w_b_mag;
            r_is_div <= i_op[1];
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_dz     <= (i_b == '0);
          end
        end
        MDS_RUN: begin
          if (r_is_div) begin
            if (!w_diff[WIDTH]) begin
              r_acc <= w_diff[WIDTH-1:0];
              r_q   <= {r_q[WIDTH-2:0], 1'b1};
            end else begin
              r_acc <= {r_acc[WIDTH-2:0], r_q[WIDTH-1]};
              r_q   <= {r_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            r_acc <= w_sum[WIDTH:1];
            r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
          end
          if (r_cnt == CW'(MD_CYCLES - 2)) begin
            r_state <= MDS_FIX;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        MDS_FIX: begin
          r_state <= MDS_IDLE;
          if (r_is_div) begin
            // Divide by zero leaves all-ones quotient; the remainder sign
            // fix still restores the original dividend into HI.
            r_lo <= r_dz ? '1 : (r_neg_q ? (~r_q + 1'b1) : r_q);
            r_hi <= r_neg_r ? (~r_acc + 1'b1) : r_acc;
          end else begin
            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_fix[WIDTH-1:0];
          end
        end
        default: r_state <= MDS_IDLE;
      endcase
    end
  end

  assign o_busy = (r_state != MDS_IDLE);
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule

// File: rtl/execute.sv
// MIPS execute stage: ALU, multiply/divide unit and the EX/MEM register.
module execute
  import exec_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned MD_CYCLES = MD_CYCLES_NOM
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       wbi,
  input  logic             mi,
  input  logic [WIDTH-1:0] rsval,
  input  logic [WIDTH-1:0] rtval,
  input  logic [WIDTH-1:0] imm,
  input  logic             alusrc,
  input  logic [4:0]       shamt,
  input  logic [3:0]       aluop,
  input  logic             mdstart,
  input  logic [1:0]       mdop,
  input  logic [4:0]       regaddr,
  output logic [1:0]       wbo,
  output logic             mo,
  output logic [WIDTH-1:0] dataaddr,
  output logic [WIDTH-1:0] data,
  output logic [4:0]       regaddrout,
  output logic             stall
);

  aluop_e           w_op;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_alu;
  logic [WIDTH-1:0] w_hi;
  logic [WIDTH-1:0] w_lo;
  logic             w_busy;

  logic [1:0]       r_wbo;
  logic             r_mo;
  logic [WIDTH-1:0] r_dataaddr;
  logic [WIDTH-1:0] r_data;
  logic [4:0]       r_regaddr;

  muldiv #(
    .WIDTH     (WIDTH),
    .MD_CYCLES (MD_CYCLES)
  ) u_muldiv (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (mdstart & ~w_busy),
    .i_op    (mdop),
    .i_a     (rsval),
    .i_b     (rtval),
    .o_hi    (w_hi),
    .o_lo    (w_lo),
    .o_busy  (w_busy)
  );

  // ALU result selection
  always_comb begin
    w_op  = aluop_e'(aluop);
    w_b   = alusrc ? imm : rtval;
    w_alu = '0;
    case (w_op)
      ALU_ADD:  w_alu = rsval + w_b;
      ALU_SUB:  w_alu = rsval - w_b;
      ALU_AND:  w_alu = rsval & w_b;
      ALU_OR:   w_alu = rsval | w_b;
      ALU_XOR:  w_alu = rsval ^ w_b;
      ALU_NOR:  w_alu = ~(rsval | w_b);
      ALU_SLT:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(rsval) < $signed(w_b))};
      ALU_SLTU: w_alu = {{(WIDTH-1){1'b0}}, (rsval < w_b)};
      ALU_SLL:  w_alu = w_b << shamt;
      ALU_SRL:  w_alu = w_b >> shamt;
      ALU_SRA:  w_alu = $unsigned($signed(w_b) >>> shamt);
      ALU_LUI:  w_alu = w_b << 16;
      ALU_MFHI: w_alu = w_hi;
      ALU_MFLO: w_alu = w_lo;
      default:  w_alu = '0;
    endcase
  end

  // Structural hazard on the busy multiply/divide unit
  always_comb begin
    stall = w_busy & ((w_op == ALU_MFHI) | (w_op == ALU_MFLO) | mdstart);
  end

  // EX/MEM register; a stalled cycle inserts a bubble and holds the data fields
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wbo      <= '0;
      r_mo       <= 1'b0;
      r_dataaddr <= '0;
      r_data     <= '0;
      r_regaddr  <= '0;
    end else if (stall) begin
      r_wbo <= '0;
      r_mo  <= 1'b0;
    end else begin
      r_wbo      <= wbi;
      r_mo       <= mi;
      r_dataaddr <= w_alu;
      r_data     <= rtval;
      r_regaddr  <= regaddr;
    end
  end

  assign wbo        = r_wbo;
  assign mo         = r_mo;
  assign dataaddr   = r_dataaddr;
  assign data       = r_data;
  assign regaddrout = r_regaddr;

endmodule

// File: tb/tb_execute.sv
// Scoreboard bench for the execute stage.
module tb_execute;
  import exec_pkg::*;

  localparam int unsigned MD = 33;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  wbi = '0;
  logic        mi = 1'b0;
  logic [31:0] rsval = '0;
  logic [31:0] rtval = '0;
  logic [31:0] imm = '0;
  logic        alusrc = 1'b0;
  logic [4:0]  shamt = '0;
  logic [3:0]  aluop = '0;
  logic        mdstart = 1'b0;
  logic [1:0]  mdop = '0;
  logic [4:0]  regaddr = '0;
  logic [1:0]  wbo;
  logic        mo;
  logic [31:0] dataaddr;
  logic [31:0] data;
  logic [4:0]  regaddrout;
  logic        stall;

  typedef struct {
    logic        bubble;
    logic [1:0]  wbo;
    logic        mo;
    logic [31:0] addr;
    logic [31:0] data;
    logic [4:0]  rd;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned busy_left = 0;

  execute #(.WIDTH(32), .MD_CYCLES(MD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wbi        (wbi),
    .mi         (mi),
    .rsval      (rsval),
    .rtval      (rtval),
    .imm        (imm),
    .alusrc     (alusrc),
    .shamt      (shamt),
    .aluop      (aluop),
    .mdstart    (mdstart),
    .mdop       (mdop),
    .regaddr    (regaddr),
    .wbo        (wbo),
    .mo         (mo),
    .dataaddr   (dataaddr),
    .data       (data),
    .regaddrout (regaddrout),
    .stall      (stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one instruction, holding it while the model predicts a stall.
  task automatic issue(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] im, input logic asrc, input logic [4:0] sh,
                       input logic mds, input logic [1:0] mdo, input logic [1:0] wb,
                       input logic m, input logic [4:0] rd, input logic [31:0] exp_addr,
                       input string tag);
    int unsigned guard;
    logic        exp_stall;
    exp_t        e;
    exp_t        g;
    guard = 0;
    do begin
      @(negedge clk);
      aluop = op; rsval = rs; rtval = rt; imm = im; alusrc = asrc; shamt = sh;
      mdstart = mds; mdop = mdo; wbi = wb; mi = m; regaddr = rd;
      exp_stall = (busy_left != 0) && (op == ALU_MFHI || op == ALU_MFLO || mds);
      #1;
      check({tag, "_stall"}, 64'(stall), 64'(exp_stall));
      e.bubble = exp_stall;
      e.wbo    = exp_stall ? 2'b00 : wb;
      e.mo     = exp_stall ? 1'b0 : m;
      e.addr   = exp_addr;
      e.data   = rt;
      e.rd     = rd;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (busy_left != 0) busy_left--;
      if (!exp_stall && mds) busy_left = MD;
      if (sb.size() == 0) begin
        check({tag, "_sb_empty"}, 64'd1, 64'd0);
      end else begin
        g = sb.pop_front();
        check({tag, "_wbo"}, 64'(wbo), 64'(g.wbo));
        check({tag, "_mo"}, 64'(mo), 64'(g.mo));
        if (!g.bubble) begin
          check({tag, "_addr"}, 64'(dataaddr), 64'(g.addr));
          check({tag, "_data"}, 64'(data), 64'(g.data));
          check({tag, "_rd"}, 64'(regaddrout), 64'(g.rd));
        end
      end
      guard++;
    end while (exp_stall && guard < 100);
    if (exp_stall) check({tag, "_timeout"}, 64'd1, 64'd0);
  endtask

  task automatic alu(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                     input logic [31:0] im, input logic asrc, input logic [4:0] sh,
                     input logic [1:0] wb, input logic m, input logic [4:0] rd,
                     input logic [31:0] exp_addr, input string tag);
    issue(op, rs, rt, im, asrc, sh, 1'b0, 2'b00, wb, m, rd, exp_addr, tag);
  endtask

  task automatic md(input logic [1:0] mdo, input logic [31:0] a, input logic [31:0] b,
                    input string tag);
    issue(ALU_ADD, a, b, 32'd0, 1'b0, 5'd0, 1'b1, mdo, 2'b00, 1'b0, 5'd0, a + b, tag);
  endtask

  task automatic mf(input logic [3:0] op, input logic [31:0] exp, input string tag);
    issue(op, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b10, 1'b0, 5'd2, exp, tag);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_wbo"}, 64'(wbo), 64'd0);
    check({tag, "_mo"}, 64'(mo), 64'd0);
    check({tag, "_addr"}, 64'(dataaddr), 64'd0);
    check({tag, "_data"}, 64'(data), 64'd0);
    check({tag, "_rd"}, 64'(regaddrout), 64'd0);
  endtask

  initial begin
    int          a;
    int          b;
    longint      p;
    logic [63:0] pu;
    logic [31:0] ua;
    logic [31:0] ub;

    #3;
    check_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // ALU path
    alu(ALU_ADD, 32'd10, 32'd0, 32'd1, 1'b1, 5'd0, 2'b11, 1'b0, 5'd13, 32'd11, "add_imm");
    alu(ALU_ADD, 32'h100, 32'hDEAD, 32'd4, 1'b1, 5'd0, 2'b00, 1'b1, 5'd0, 32'h104, "store");
    alu(ALU_ADD, 32'd1, 32'd100, 32'd2, 1'b1, 5'd0, 2'b10, 1'b0, 5'd4, 32'd3, "alusrc_imm");
    alu(ALU_ADD, 32'hFFFFFFFF, 32'd0, 32'd1, 1'b1, 5'd0, 2'b10, 1'b0, 5'd5, 32'd0, "add_wrap");
    alu(ALU_SUB, 32'd5, 32'd7, 32'd0, 1'b0, 5'd0, 2'b10, 1'b0, 5'd6, 32'hFFFFFFFE, "sub");
    alu(ALU_AND, 32'hF0F0, 32'hFF00, 32'd0, 1'b0, 5'd0, 2'b10, 1'b0, 5'd7, 32'hF000, "and");
    alu(ALU_OR, 32'hF0F0, 32'h0F00, 32'd0, 1'b0, 5'd0, 2'b10, 1'b0, 5'd8, 32'hFFF0, "or");
    alu(ALU_XOR, 32'hFF00, 32'h0FF0, 32'd0, 1'b0, 5'd0, 2'b10, 1'b0, 5'd9, 32'hF0F0, "xor");
    alu(ALU_NOR, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 2'b10, 1'b0, 5'd10, 32'hFFFFFFFF, "nor");
    alu(ALU_SLT, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 5'd0, 2'b10, 1'b0, 5'd11, 32'd1, "slt");
    alu(ALU_SLTU, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 5'd0, 2'b10, 1'b0, 5'd12, 32'd0, "sltu");
    alu(ALU_SRA, 32'd0, 32'h80000000, 32'd0, 1'b0, 5'd4, 2'b10, 1'b0, 5'd14, 32'hF8000000, "sra");
    alu(ALU_SRL, 32'd0, 32'h80000000, 32'd0, 1'b0, 5'd4, 2'b10, 1'b0, 5'd15, 32'h08000000, "srl");
    alu(ALU_SLL, 32'd0, 32'd1, 32'd0, 1'b0, 5'd31, 2'b10, 1'b0, 5'd16, 32'h80000000, "sll");
    alu(ALU_LUI, 32'd0, 32'd0, 32'h1234, 1'b1, 5'd0, 2'b10, 1'b0, 5'd17, 32'h12340000, "lui");

    // Multiply / divide with hand-computed results
    md(MD_MULT, 32'hFFFFFFFD, 32'd7, "mult");
    mf(ALU_MFLO, 32'hFFFFFFEB, "mult_lo");
    mf(ALU_MFHI, 32'hFFFFFFFF, "mult_hi");
    md(MD_DIV, 32'hFFFFFFF9, 32'd2, "div");
    mf(ALU_MFLO, 32'hFFFFFFFD, "div_lo");
    mf(ALU_MFHI, 32'hFFFFFFFF, "div_hi");
    md(MD_DIVU, 32'd5, 32'd0, "divu0");
    mf(ALU_MFLO, 32'hFFFFFFFF, "divu0_lo");
    mf(ALU_MFHI, 32'd5, "divu0_hi");
    md(MD_DIV, 32'hFFFFFFF9, 32'd0, "div0");
    mf(ALU_MFHI, 32'hFFFFFFF9, "div0_hi");
    mf(ALU_MFLO, 32'hFFFFFFFF, "div0_lo");
    md(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu");
    mf(ALU_MFHI, 32'hFFFFFFFE, "multu_hi");
    mf(ALU_MFLO, 32'h00000001, "multu_lo");

    // Back-to-back start: the second one stalls until the first completes
    md(MD_MULTU, 32'd3, 32'd4, "b2b_first");
    md(MD_MULTU, 32'd6, 32'd7, "b2b_second");
    mf(ALU_MFLO, 32'd42, "b2b_lo");

    // Randomised operands, results from native arithmetic
    for (int i = 0; i < 3; i++) begin
      a = int'($urandom);
      b = int'($urandom);
      p = longint'(a) * longint'(b);
      md(MD_MULT, a, b, "rmult");
      mf(ALU_MFLO, p[31:0], "rmult_lo");
      mf(ALU_MFHI, p[63:32], "rmult_hi");
      ua = $urandom;
      ub = $urandom;
      pu = {32'd0, ua} * {32'd0, ub};
      md(MD_MULTU, ua, ub, "rmultu");
      mf(ALU_MFHI, pu[63:32], "rmultu_hi");
      a = int'($urandom_range(2000000000, 0)) - 1000000000;
      b = int'($urandom_range(60000, 1)) - 30000;
      if (b == 0) b = 3;
      md(MD_DIV, a, b, "rdiv");
      mf(ALU_MFLO, a / b, "rdiv_lo");
      mf(ALU_MFHI, a % b, "rdiv_hi");
      ua = $urandom;
      ub = $urandom_range(100000, 1);
      md(MD_DIVU, ua, ub, "rdivu");
      mf(ALU_MFLO, ua / ub, "rdivu_lo");
      mf(ALU_MFHI, ua % ub, "rdivu_hi");
    end

    // Asynchronous reset in the middle of a divide
    md(MD_DIV, 32'hFFFFFF9C, 32'd7, "rst_div");
    for (int i = 0; i < 9; i++) begin
      alu(ALU_ADD, 32'd20, 32'd3, 32'd1, 1'b1, 5'd0, 2'b11, 1'b1, 5'd9, 32'd21, "rst_fill");
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midreset");
    check("midreset_stall", 64'(stall), 64'd0);
    busy_left = 0;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    mf(ALU_MFHI, 32'd0, "postrst_hi");
    mf(ALU_MFLO, 32'd0, "postrst_lo");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/execute.md
# execute

Execute stage of the five-stage MIPS pipeline, between the ID/EX register and the memory stage. Computes the ALU result (load/store address or writeback value), runs an iterative multiply/divide unit into HI/LO, and registers everything into the EX/MEM boundary. It also raises a structural stall when an instruction needs the busy multiply/divide unit.

## Interface
Parameters:
- WIDTH, 32, datapath width
- MD_CYCLES, 33, multiply/divide busy length (32 iterations + 1 sign fix-up)

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- wbi  in  2  writeback control from ID/EX (bit1 reg write, bit0 mem-to-reg)
- mi  in  1  memory write enable from ID/EX
- rsval  in  32  rs operand
- rtval  in  32  rt operand (also store data)
- imm  in  32  sign/zero-extended immediate
- alusrc  in  1  1: B operand = imm, 0: B = rtval
- shamt  in  5  shift amount
- aluop  in  4  ALU operation code (package enum)
- mdstart  in  1  start multiply/divide this cycle
- mdop  in  2  MULT, MULTU, DIV, DIVU
- regaddr  in  5  destination register
- wbo  out  2  registered writeback control
- mo  out  1  registered memory write enable (drives memory stage M)
- dataaddr  out  32  registered ALU result
- data  out  32  registered store data (rtval)
- regaddrout  out  5  registered destination register
- stall  out  1  combinational; hold PC and IF/ID, ID/EX

## Operation
- ALU ops: ADD, SUB (wrap-around, no overflow trap), AND, OR, XOR, NOR, SLT (signed), SLTU, SLL/SRL/SRA by shamt on B, LUI (B<<16), MFHI, MFLO.
- Operand A = rsval; B = alusrc ? imm : rtval.
- Multiply/divide FSM: IDLE -> RUN (32 iterations, shift-add / restoring divide on magnitudes) -> FIX (negate per sign) -> IDLE.
- Signed multiply: 64-bit product negated if operand signs differ; HI = upper, LO = lower.
- Signed divide: quotient negative if signs differ; remainder takes dividend sign. LO = quotient, HI = remainder.
- Divide by zero: LO = 32'hFFFFFFFF, HI = dividend; normal cycle count.
- busy high from the cycle after start until HI/LO are written.
- stall = busy & (aluop is MFHI/MFLO or mdstart).
- On stall: EX/MEM gets a bubble (wbo=0, mo=0, other fields don't-care but held). mdstart is ignored; no new operation is accepted.
- An mdstart instruction itself enters EX/MEM with its own wbi/mi (the decoder sends 0).

## Timing
- ALU path: inputs at cycle T; outputs valid after edge T+1 (1-cycle latency).
- mdstart accepted at edge T0; busy = 1 for exactly MD_CYCLES cycles; HI/LO updated at edge T0+MD_CYCLES, when busy drops.
- MFHI presented while busy stalls until busy drops, then reads the new HI the following edge.
- Back-to-back mdstart with busy=0 is legal every MD_CYCLES+1 cycles.
- Reset (asynchronous, any time, including mid-operation): wbo=0, mo=0, dataaddr=0, data=0, regaddrout=0, HI=LO=0, busy=0, FSM=IDLE, iteration counter=0. Any in-flight operation is discarded.

## Structure
- Package exec_pkg: aluop enum (4-bit), mdop enum (2-bit), MD_CYCLES constant, wb bit positions.
- Sub-module muldiv: FSM, counter, HI/LO, busy.
- The ALU and the EX/MEM register stay in execute.

## Test plan
- Reset mid-DIV at cycle 10 -> busy=0, HI=LO=0, all outputs 0 immediately.
- ADD rs=10, imm=1, alusrc=1, wbi=3, regaddr=13 -> next edge: dataaddr=11, wbo=3, regaddrout=13, mo=0.
- Store: alusrc=1, rs=0x100, imm=4, rt=0xDEAD, mi=1 -> dataaddr=0x104, data=0xDEAD, mo=1.
- MULT rs=-3, rt=7, then MFLO the next cycle -> stall high for 33 cycles with bubbles (wbo=0, mo=0), then dataaddr=0xFFFFFFEB; MFHI -> 0xFFFFFFFF.
- DIV rs=-7, rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU rs=5, rt=0 -> LO=0xFFFFFFFF, HI=5.
- SLT -1 vs 1 -> 1; SLTU same operands -> 0; SRA 0x80000000 by 4 -> 0xF8000000.
